// File: rtl/linebuf_wrctrl.sv
// linebuf_wrctrl: write-side controller for the line-doubler RAM; turns the pixel stream into page/addr/data writes.
// Latency: one VCLK from a pixel strobe to its RAM write and from a line-ending strobe to the line report.
// Backpressure: none; one RAM write per strobe, so back-to-back strobes are absorbed at one write per cycle.
//
// Ports:
//   VCLK, RST              video clock, synchronous active-high reset
//   vdata_valid_i          pixel strobe; syncs and data are only looked at while it is high
//   vsync_n_i, hsync_n_i   active-low syncs
//   vdata_i                pixel {R,G,B}
//   hstart_i               leading pixels to drop per line (only with LINEBUF_HSTART_EN)
//   wren_o/wrpage_o/wraddr_o/wrdata_o   RAM write port
//   line_done_o            one-cycle pulse when a line is complete
//   line_page_o/line_len_o page and pixel count of that line, held until the next pulse
//   overflow_o             sticky: a line had more pixels than a page holds; cleared at vblank
//
// Build option: define LINEBUF_HSTART_EN to add hstart_i and the SKIP state.

module linebuf_wrctrl #(
    parameter  int num_of_pages = 2,
    parameter  int pagesize     = 1024,
    parameter  int color_width  = 7,
    localparam int PW           = $clog2(num_of_pages),
    localparam int AW           = $clog2(pagesize),
    localparam int DW           = 3 * color_width,
    localparam int CW           = AW + 1
) (
    input  logic          VCLK,
    input  logic          RST,
    input  logic          vdata_valid_i,
    input  logic          vsync_n_i,
    input  logic          hsync_n_i,
    input  logic [DW-1:0] vdata_i,
`ifdef LINEBUF_HSTART_EN
    input  logic [AW-1:0] hstart_i,
`endif
    output logic          wren_o,
    output logic [PW-1:0] wrpage_o,
    output logic [AW-1:0] wraddr_o,
    output logic [DW-1:0] wrdata_o,
    output logic          line_done_o,
    output logic [PW-1:0] line_page_o,
    output logic [CW-1:0] line_len_o,
    output logic          overflow_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VBLANK = 3'd1,
        HBLANK = 3'd2,
        SKIP   = 3'd3,
        ACTIVE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          vs_q, vs_d;       // syncs as seen at the previous strobe
    logic          hs_q, hs_d;
    logic [PW-1:0] page_q, page_d;
    logic [CW-1:0] cnt_q, cnt_d;     // pixels accepted this line; saturates at pagesize
    logic          ovf_q, ovf_d;
    logic          wren_q, wren_d;
    logic [PW-1:0] wrpage_q, wrpage_d;
    logic [AW-1:0] wraddr_q, wraddr_d;
    logic [DW-1:0] wrdata_q, wrdata_d;
    logic          done_q, done_d;
    logic [PW-1:0] lpage_q, lpage_d;
    logic [CW-1:0] llen_q, llen_d;
`ifdef LINEBUF_HSTART_EN
    logic [AW-1:0] skip_q, skip_d;   // strobes still to drop after the current one
`endif

    logic vs_fall;
    logic hs_fall;
    logic both_hi;
    logic start_line;
    logic pix_wr;
    logic line_end;
    logic enter_vb;

    // Edges are relative to the previous strobe, not the previous clock,
    // because the syncs are only meaningful alongside the pixel strobe.
    assign vs_fall = !vsync_n_i && vs_q;
    assign hs_fall = !hsync_n_i && hs_q;
    assign both_hi = vsync_n_i && hsync_n_i;

    always_comb begin
        state_d    = state_q;
        vs_d       = vs_q;
        hs_d       = hs_q;
        page_d     = page_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        wren_d     = 1'b0;
        wrpage_d   = wrpage_q;
        wraddr_d   = wraddr_q;
        wrdata_d   = wrdata_q;
        done_d     = 1'b0;
        lpage_d    = lpage_q;
        llen_d     = llen_q;
`ifdef LINEBUF_HSTART_EN
        skip_d     = skip_q;
`endif
        start_line = 1'b0;
        pix_wr     = 1'b0;
        line_end   = 1'b0;
        enter_vb   = 1'b0;

        if (vdata_valid_i) begin
            vs_d = vsync_n_i;
            hs_d = hsync_n_i;

            // A vsync fall is checked first everywhere so it beats a
            // simultaneous hsync fall and discards the partial line.
            case (state_q)
                IDLE: begin
                    if (!vsync_n_i) begin
                        enter_vb = 1'b1;
                    end
                end
                VBLANK: begin
                    if (vs_fall) begin
                        enter_vb = 1'b1;
                    end else if (vsync_n_i) begin
                        if (hsync_n_i) begin
                            start_line = 1'b1;
                        end else begin
                            state_d = HBLANK;
                        end
                    end
                end
                HBLANK: begin
                    if (vs_fall) begin
                        enter_vb = 1'b1;
                    end else if (both_hi) begin
                        start_line = 1'b1;
                    end
                end
`ifdef LINEBUF_HSTART_EN
                SKIP: begin
                    if (vs_fall) begin
                        enter_vb = 1'b1;
                    end else if (hs_fall) begin
                        line_end = 1'b1;
                    end else if (both_hi) begin
                        if (skip_q == '0) begin
                            pix_wr  = 1'b1;
                            state_d = ACTIVE;
                        end else begin
                            skip_d = skip_q - 1'b1;
                        end
                    end
                end
`endif
                ACTIVE: begin
                    if (vs_fall) begin
                        enter_vb = 1'b1;
                    end else if (hs_fall) begin
                        line_end = 1'b1;
                    end else if (both_hi) begin
                        pix_wr = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // The strobe on which hsync rises is already the line's first pixel.
        if (start_line) begin
`ifdef LINEBUF_HSTART_EN
            if (hstart_i != '0) begin
                // This strobe is the first dropped one; hstart_i is latched here.
                state_d = SKIP;
                skip_d  = hstart_i - 1'b1;
            end else begin
                state_d = ACTIVE;
                pix_wr  = 1'b1;
            end
`else
            state_d = ACTIVE;
            pix_wr  = 1'b1;
`endif
        end

        if (pix_wr) begin
            if (cnt_q < CW'(pagesize)) begin
                wren_d   = 1'b1;
                wrpage_d = page_q;
                wraddr_d = cnt_q[AW-1:0];
                wrdata_d = vdata_i;
                cnt_d    = cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (line_end) begin
            done_d  = 1'b1;
            lpage_d = page_q;
            llen_d  = cnt_q;
            page_d  = (page_q == PW'(num_of_pages - 1)) ? '0 : page_q + 1'b1;
            cnt_d   = '0;
            state_d = HBLANK;
        end

        if (enter_vb) begin
            state_d = VBLANK;
            page_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            state_q  <= IDLE;
            vs_q     <= 1'b1;
            hs_q     <= 1'b1;
            page_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            wren_q   <= 1'b0;
            wrpage_q <= '0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            done_q   <= 1'b0;
            lpage_q  <= '0;
            llen_q   <= '0;
`ifdef LINEBUF_HSTART_EN
            skip_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vs_q     <= vs_d;
            hs_q     <= hs_d;
            page_q   <= page_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            wren_q   <= wren_d;
            wrpage_q <= wrpage_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            done_q   <= done_d;
            lpage_q  <= lpage_d;
            llen_q   <= llen_d;
`ifdef LINEBUF_HSTART_EN
            skip_q   <= skip_d;
`endif
        end
    end

    assign wren_o      = wren_q;
    assign wrpage_o    = wrpage_q;
    assign wraddr_o    = wraddr_q;
    assign wrdata_o    = wrdata_q;
    assign line_done_o = done_q;
    assign line_page_o = lpage_q;
    assign line_len_o  = llen_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_linebuf_wrctrl.sv
// tb_linebuf_wrctrl: directed line/frame stimulus for linebuf_wrctrl with a line-level expectation model.
// Latency: expectations are queued at the clock edge that samples each strobe and checked at the next negedge.
// Backpressure: none; the bench drives strobes at a fixed spacing and never waits on the DUT.

module tb_linebuf_wrctrl;

    localparam int NP = 2;
    localparam int PS = 1024;
    localparam int PW = 1;
    localparam int AW = 10;
    localparam int DW = 21;
`ifdef LINEBUF_HSTART_EN
    localparam int HS = 8;
`else
    localparam int HS = 0;
`endif

    logic          VCLK = 1'b0;
    logic          RST = 1'b1;
    logic          vdata_valid_i = 1'b0;
    logic          vsync_n_i = 1'b1;
    logic          hsync_n_i = 1'b1;
    logic [DW-1:0] vdata_i = '0;
`ifdef LINEBUF_HSTART_EN
    logic [AW-1:0] hstart_i = AW'(HS);
`endif
    logic          wren_o;
    logic [PW-1:0] wrpage_o;
    logic [AW-1:0] wraddr_o;
    logic [DW-1:0] wrdata_o;
    logic          line_done_o;
    logic [PW-1:0] line_page_o;
    logic [AW:0]   line_len_o;
    logic          overflow_o;

    linebuf_wrctrl #(
        .num_of_pages(NP),
        .pagesize    (PS),
        .color_width (7)
    ) dut (
        .VCLK         (VCLK),
        .RST          (RST),
        .vdata_valid_i(vdata_valid_i),
        .vsync_n_i    (vsync_n_i),
        .hsync_n_i    (hsync_n_i),
        .vdata_i      (vdata_i),
`ifdef LINEBUF_HSTART_EN
        .hstart_i     (hstart_i),
`endif
        .wren_o       (wren_o),
        .wrpage_o     (wrpage_o),
        .wraddr_o     (wraddr_o),
        .wrdata_o     (wrdata_o),
        .line_done_o  (line_done_o),
        .line_page_o  (line_page_o),
        .line_len_o   (line_len_o),
        .overflow_o   (overflow_o)
    );

    always #5 VCLK = ~VCLK;

    typedef struct packed { logic [PW-1:0] pg; logic [AW-1:0] ad; logic [DW-1:0] d; } wr_t;
    typedef struct packed { logic [PW-1:0] pg; logic [AW:0] ln; } dn_t;
    typedef struct { string nm; int sel; longint act; longint exp; } lit_t;

    wr_t  wr_q[$];
    dn_t  dn_q[$];
    lit_t lit_q[$];

    int vecs = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Model state: what the outputs must show, derived from the line structure being sent.
    logic          exp_ovf = 1'b0;
    logic [PW-1:0] exp_lpage = '0;
    logic [AW:0]   exp_llen = '0;
    int            m_page = 0;
    bit            m_armed = 1'b0;
    int            line_no = 0;

    // Observations logged by the compare process.
    int            log_addr[$];
    int            log_page[$];
    logic [DW-1:0] log_data[$];
    int            n_done = 0;

    function automatic logic [DW-1:0] pix(input int l, input int p);
        logic [31:0] v;
        v = (l << 11) | p;
        return v[DW-1:0];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input int sel, input longint act, input longint exp);
        lit_t l;
        l.nm = nm; l.sel = sel; l.act = act; l.exp = exp;
        lit_q.push_back(l);
    endtask

    always @(negedge VCLK) begin
        if (checking) begin
            wr_t    e;
            dn_t    dd;
            lit_t   l;
            longint a;
            chk("wren_o", longint'(wren_o), longint'(wr_q.size() != 0));
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                if (wren_o) begin
                    chk("wrpage_o", longint'(wrpage_o), longint'(e.pg));
                    chk("wraddr_o", longint'(wraddr_o), longint'(e.ad));
                    chk("wrdata_o", longint'(wrdata_o), longint'(e.d));
                end
            end
            if (wren_o) begin
                log_addr.push_back(int'(wraddr_o));
                log_page.push_back(int'(wrpage_o));
                log_data.push_back(wrdata_o);
            end
            chk("line_done_o", longint'(line_done_o), longint'(dn_q.size() != 0));
            if (dn_q.size() != 0) begin
                dd = dn_q.pop_front();
                if (line_done_o) begin
                    chk("done page", longint'(line_page_o), longint'(dd.pg));
                    chk("done len", longint'(line_len_o), longint'(dd.ln));
                end
            end
            if (line_done_o) n_done++;
            chk("overflow_o", longint'(overflow_o), longint'(exp_ovf));
            chk("line_page_o", longint'(line_page_o), longint'(exp_lpage));
            chk("line_len_o", longint'(line_len_o), longint'(exp_llen));
            while (lit_q.size() != 0) begin
                l = lit_q.pop_front();
                case (l.sel)
                    1:       a = longint'(wren_o);
                    2:       a = longint'(wrpage_o);
                    3:       a = longint'(wraddr_o);
                    4:       a = longint'(wrdata_o);
                    5:       a = longint'(line_done_o);
                    6:       a = longint'(line_page_o);
                    7:       a = longint'(line_len_o);
                    8:       a = longint'(overflow_o);
                    default: a = l.act;
                endcase
                chk(l.nm, a, l.exp);
            end
        end
    end

    // Presents one strobe; returns at the edge that samples it.
    task automatic drive(input logic vs, input logic hs, input logic [DW-1:0] d);
        vdata_valid_i = 1'b1;
        vsync_n_i     = vs;
        hsync_n_i     = hs;
        vdata_i       = d;
        @(posedge VCLK);
    endtask

    task automatic idle_gap(input int g);
        #1;
        vdata_valid_i = 1'b0;
        repeat (g) @(posedge VCLK);
        #1;
    endtask

    // Vsync fall (optionally with hsync falling too), vblank, then hsync low.
    task automatic send_vsync(input logic first_hs);
        drive(1'b0, first_hs, '0);
        m_armed = 1'b1;
        m_page  = 0;
        exp_ovf = 1'b0;
        idle_gap(3);
        drive(1'b0, 1'b1, '0);
        idle_gap(3);
        repeat (2) begin
            drive(1'b1, 1'b0, '0);
            idle_gap(3);
        end
    endtask

    // ending: 0 hsync fall, 1 vsync fall, 2 vsync+hsync fall, 3 none
    task automatic send_line(input int n, input int gap, input int ending);
        int            kept;
        int            len;
        logic [DW-1:0] d;
        kept = 0;
        for (int p = 0; p < n; p++) begin
            d = pix(line_no, p);
            drive(1'b1, 1'b1, d);
            if (m_armed && p >= HS) begin
                if (kept < PS) wr_q.push_back('{pg: PW'(m_page), ad: AW'(kept), d: d});
                else exp_ovf = 1'b1;
                kept++;
            end
            idle_gap(gap);
        end
        if (ending == 0) begin
            drive(1'b1, 1'b0, '0);
            if (m_armed) begin
                len = (kept < PS) ? kept : PS;
                dn_q.push_back('{pg: PW'(m_page), ln: (AW+1)'(len)});
                exp_lpage = PW'(m_page);
                exp_llen  = (AW+1)'(len);
                m_page    = (m_page + 1) % NP;
            end
            idle_gap(gap);
            repeat (2) begin
                drive(1'b1, 1'b0, '0);
                idle_gap(gap);
            end
        end else if (ending == 1) begin
            send_vsync(1'b1);
        end else if (ending == 2) begin
            send_vsync(1'b0);
        end
        line_no++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw0;
        int nd0;
        int ln;

        repeat (2) @(posedge VCLK);
        #1;
        checking = 1'b1;
        lit("reset wren", 1, 0, 0);
        lit("reset wraddr", 3, 0, 0);
        lit("reset line_done", 5, 0, 0);
        lit("reset line_len", 7, 0, 0);
        lit("reset overflow", 8, 0, 0);
        RST = 1'b0;
        @(posedge VCLK);
        #1;

        // Three normal lines: pages 0,1,0, 640 writes each.
        send_vsync(1'b1);
        for (int i = 0; i < 3; i++) begin
            nw0 = log_addr.size();
            ln  = line_no;
            send_line(640 + HS, 3, 0);
            lit("line len 640", 7, 0, 640);
            lit("line page alternates", 6, 0, i % 2);
            lit("writes per line", 0, log_addr.size() - nw0, 640);
            lit("first addr", 0, log_addr[nw0], 0);
            lit("first data", 0, longint'(log_data[nw0]), longint'(pix(ln, HS)));
            lit("last addr", 0, log_addr[log_addr.size() - 1], 639);
        end

        // Overlong line, back-to-back strobes.
        nw0 = log_addr.size();
        send_line(1030 + HS, 0, 0);
        lit("ovf line len", 7, 0, 1024);
        lit("ovf sticky", 8, 0, 1);
        lit("ovf writes", 0, log_addr.size() - nw0, 1024);
        lit("ovf last addr", 0, log_addr[log_addr.size() - 1], 1023);
        send_vsync(1'b1);
        lit("ovf cleared by vsync", 8, 0, 0);

        // Vsync falls mid-line on page 1.
        send_line(640 + HS, 3, 0);
        nd0 = n_done;
        send_line(100 + HS, 3, 1);
        lit("abort no done", 0, n_done - nd0, 0);
        nw0 = log_addr.size();
        send_line(640 + HS, 3, 0);
        lit("after abort page", 0, log_page[nw0], 0);
        lit("after abort addr", 0, log_addr[nw0], 0);
        lit("after abort done page", 6, 0, 0);

        // Vsync and hsync fall together on page 1.
        nd0 = n_done;
        send_line(50 + HS, 3, 2);
        lit("both-fall no done", 0, n_done - nd0, 0);
        nw0 = log_addr.size();
        send_line(640 + HS, 3, 0);
        lit("after both-fall page", 0, log_page[nw0], 0);
        lit("after both-fall len", 7, 0, 640);

        // Reset mid-line at pixel 300.
        send_line(300 + HS, 3, 3);
        RST = 1'b1;
        @(posedge VCLK);
        m_armed   = 1'b0;
        m_page    = 0;
        exp_ovf   = 1'b0;
        exp_lpage = '0;
        exp_llen  = '0;
        #1;
        RST = 1'b0;
        lit("rst wren", 1, 0, 0);
        lit("rst wrpage", 2, 0, 0);
        lit("rst wraddr", 3, 0, 0);
        lit("rst wrdata", 4, 0, 0);
        lit("rst line_done", 5, 0, 0);
        lit("rst line_len", 7, 0, 0);
        lit("rst overflow", 8, 0, 0);
        @(posedge VCLK);
        #1;
        nw0 = log_addr.size();
        nd0 = n_done;
        send_line(20, 3, 0);
        lit("idle no writes", 0, log_addr.size() - nw0, 0);
        lit("idle no done", 0, n_done - nd0, 0);
        send_vsync(1'b1);
        nw0 = log_addr.size();
        send_line(640 + HS, 3, 0);
        lit("post-reset page", 0, log_page[nw0], 0);
        lit("post-reset addr", 0, log_addr[nw0], 0);
        lit("post-reset len", 7, 0, 640);

        repeat (3) @(posedge VCLK);
        #1;
        lit("writes drained", 0, wr_q.size(), 0);
        lit("dones drained", 0, dn_q.size(), 0);
        repeat (2) @(negedge VCLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
